delayed_value_checker: RTL and testbench



---
 rtl/delayed_value_checker.sv | 153 +++++++++++++++
 tb/tb_delayed_value_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/delayed_value_checker.sv
// rtl/delayed_value_checker.sv - cycle-counted unloaded/loaded check of a periodic-load register
// Optional CHECKER_CONTINUOUS_EN keeps watching the value after a pass and flags later changes.
module delayed_value_checker #(
  parameter int                 WIDTH    = 4,
  parameter logic [WIDTH-1:0]   EXPECT   = 4'h5,
  parameter int                 INIT_DLY = 1,
  parameter int                 LOAD_DLY = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             value_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code
);

  localparam logic [15:0] INIT_CNT = 16'(INIT_DLY);
  localparam logic [15:0] LOAD_CNT = 16'(INIT_DLY + LOAD_DLY);

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_EARLY   = 2'd1;
  localparam logic [1:0] CODE_BADLOAD = 2'd2;
`ifdef CHECKER_CONTINUOUS_EN
  localparam logic [1:0] CODE_CHANGED = 2'd3;
`endif

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    WAIT_LOAD,
`ifdef CHECKER_CONTINUOUS_EN
    MONITOR,
`endif
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [1:0]  fail_code_q, fail_code_d;

  logic [15:0] cnt_inc;
  logic        value_ok;

  assign cnt_inc  = cnt_q + 16'd1;
  assign value_ok = value_valid && (value == EXPECT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_code_d = fail_code_q;

    // Restart is only honoured when no sequence is running.
    if (start && !busy_q) begin
      state_d     = WAIT_INIT;
      cnt_d       = 16'd0;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      fail_code_d = CODE_NONE;
    end else begin
      case (state_q)
        WAIT_INIT: begin
          cnt_d = cnt_inc;
          if (cnt_inc == INIT_CNT) begin
            if (value_valid) begin
              state_d     = DONE;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              fail_d      = 1'b1;
              fail_code_d = CODE_EARLY;
            end else begin
              state_d = WAIT_LOAD;
            end
          end
        end
        WAIT_LOAD: begin
          cnt_d = cnt_inc;
          if (cnt_inc == LOAD_CNT) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            if (value_ok) begin
              pass_d = 1'b1;
`ifdef CHECKER_CONTINUOUS_EN
              state_d = MONITOR;
`else
              state_d = DONE;
`endif
            end else begin
              state_d     = DONE;
              fail_d      = 1'b1;
              fail_code_d = CODE_BADLOAD;
            end
          end
        end
`ifdef CHECKER_CONTINUOUS_EN
        MONITOR: begin
          if (!value_ok) begin
            state_d     = DONE;
            pass_d      = 1'b0;
            fail_d      = 1'b1;
            fail_code_d = CODE_CHANGED;
          end
        end
`endif
        IDLE, DONE: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= CODE_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;

endmodule

// File: tb/tb_delayed_value_checker.sv
// tb/tb_delayed_value_checker.sv - directed bench for delayed_value_checker at default parameters
module tb_delayed_value_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] value;
  logic       value_valid;
  logic       busy, done, pass, fail;
  logic [1:0] fail_code;

  int errors = 0;
  int checks = 0;

  delayed_value_checker dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .fail_code   (fail_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // status = {busy, done, pass, fail, fail_code}
  task automatic check_status(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, busy, done, pass, fail, fail_code}, {26'd0, exp});
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench just after edge E0.
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; value = 4'h0; value_valid = 1'b0;
    tick(2);
    reset = 1'b0;
    check_status("reset_state", 6'b0000_00);

    // Normal pass: value loads 10 cycles after E0.
    pulse_start();
    check_status("pass_after_e0", 6'b1000_00);
    tick(1);
    check_status("pass_after_init", 6'b1000_00);
    tick(9);
    value = 4'h5; value_valid = 1'b1;
    tick(5);
    check_status("pass_e0p15_busy", 6'b1000_00);
    tick(1);
    check_status("pass_e0p16", 6'b0110_00);

    // Already loaded at the initial check.
    pulse_start();
    check_status("early_after_e0", 6'b1000_00);
    tick(1);
    check_status("early_e0p1", 6'b0101_01);
    tick(20);
    check_status("early_no_load_check", 6'b0101_01);

    // Wrong value loaded.
    value_valid = 1'b0;
    pulse_start();
    check_status("wrong_restart_clears", 6'b1000_00);
    tick(1);
    value = 4'h3; value_valid = 1'b1;
    tick(14);
    check_status("wrong_e0p15", 6'b1000_00);
    tick(1);
    check_status("wrong_e0p16", 6'b0101_10);

    // Never loaded.
    value_valid = 1'b0;
    pulse_start();
    check_status("unloaded_after_e0", 6'b1000_00);
    tick(16);
    check_status("unloaded_e0p16", 6'b0101_10);

    // Reset mid-sequence at E0+8.
    value = 4'h5;
    pulse_start();
    tick(7);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_status("reset_abort", 6'b0000_00);
    value_valid = 1'b1;
    tick(20);
    check_status("reset_stays_idle", 6'b0000_00);

    // Reset wins over start on the same edge.
    value_valid = 1'b0;
    reset = 1'b1; start = 1'b1;
    tick(1);
    reset = 1'b0; start = 1'b0;
    check_status("reset_beats_start", 6'b0000_00);

    // Normal pass after reset.
    pulse_start();
    tick(10);
    value = 4'h5; value_valid = 1'b1;
    tick(6);
    check_status("post_reset_pass", 6'b0110_00);

    // Start during a run is ignored; timing still from original E0.
    value_valid = 1'b0;
    pulse_start();
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    value = 4'h5; value_valid = 1'b1;
    tick(10);
    check_status("ignore_start_e0p15", 6'b1000_00);
    tick(1);
    check_status("ignore_start_e0p16", 6'b0110_00);

    // Restart from DONE with the value already loaded.
    pulse_start();
    check_status("done_restart_clears", 6'b1000_00);
    tick(1);
    check_status("done_restart_early", 6'b0101_01);

    // Change after pass: value goes to 6 at E0+20.
    value_valid = 1'b0;
    pulse_start();
    tick(10);
    value = 4'h5; value_valid = 1'b1;
    tick(6);
    check_status("cont_pass_e0p16", 6'b0110_00);
    tick(3);
    check_status("cont_hold_e0p19", 6'b0110_00);
    value = 4'h6;
    tick(1);
`ifdef CHECKER_CONTINUOUS_EN
    check_status("cont_change_e0p20", 6'b0101_11);
`else
    check_status("cont_change_e0p20", 6'b0110_00);
`endif
    tick(3);
`ifdef CHECKER_CONTINUOUS_EN
    check_status("cont_change_hold", 6'b0101_11);
`else
    check_status("cont_change_hold", 6'b0110_00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
